// File: rtl/poly_reduce_pkg.sv
// Shared definitions for the polynomial reducer: FSM state encoding,
// fold-counter sizing and coefficient slice positioning.
package poly_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Fold counter width: clog2(D-1), never less than one bit.
  function automatic int cnt_width(input int d);
    int w;
    w = $clog2(d - 1);
    if (w < 1) w = 1;
    return w;
  endfunction

  // LSB position of coefficient idx in a packed vector of n-bit coefficients.
  function automatic int coef_lsb(input int idx, input int n);
    return idx * n;
  endfunction

endpackage

// File: rtl/coeff_mod_addsub.sv
// N-bit wrapping coefficient combiner used by the fold step.
// Build option CYCLIC_REDUCE_EN: add (reduce mod x^D - 1);
// otherwise subtract (reduce mod x^D + 1).
module coeff_mod_addsub #(
  parameter int N = 4
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] y
);

`ifdef CYCLIC_REDUCE_EN
  // x^D = 1: high coefficient adds onto its low partner, carry discarded.
  assign y = a + b;
`else
  // x^D = -1: high coefficient subtracts from its low partner, borrow discarded.
  assign y = a - b;
`endif

endmodule

// File: rtl/negacyclic_poly_reducer.sv
// Folds a (2D-1)-coefficient product modulo x^D + 1 into D coefficients,
// one high coefficient per cycle. Valid/ready on both sides.
// Build option CYCLIC_REDUCE_EN switches the fold to modulo x^D - 1.
module negacyclic_poly_reducer
  import poly_reduce_pkg::*;
#(
  parameter int N = 4,
  parameter int D = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [(2*D-1)*N-1:0]   p_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [D*N-1:0]         r_out,
  output logic                   busy
);

  localparam int            KW     = cnt_width(D);
  localparam logic [KW-1:0] K_LAST = KW'(D - 2);

  state_t        state;
  state_t        state_nxt;
  logic [KW-1:0] k;
  logic [N-1:0]  acc [D];
  logic [N-1:0]  hi  [D-1];
  logic [N-1:0]  fold_res;
  logic          accept;
  logic          fold_en;

  // Single shared combiner: acc[k] op hi[k] for the current fold step.
  coeff_mod_addsub #(
    .N (N)
  ) u_addsub (
    .a (acc[k]),
    .b (hi[k]),
    .y (fold_res)
  );

  // Next-state and handshake decode; in_ready is held low while reset is asserted.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    fold_en   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst;
        accept   = in_valid && rst;
        if (accept) state_nxt = FOLD;
      end
      FOLD: begin
        busy    = 1'b1;
        fold_en = 1'b1;
        if (k == K_LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; asynchronous reset aborts any fold in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Fold counter: cleared on acceptance, stops at D-2 on the last fold step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k <= '0;
    end else if (accept) begin
      k <= '0;
    end else if (fold_en && (k != K_LAST)) begin
      k <= k + 1'b1;
    end
  end

  // Coefficient storage: capture the product, then fold hi[k] into acc[k]; acc[D-1] is never folded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D; i++)     acc[i] <= '0;
      for (int i = 0; i < D - 1; i++) hi[i]  <= '0;
    end else if (accept) begin
      for (int i = 0; i < D; i++)     acc[i] <= p_in[coef_lsb(i, N) +: N];
      for (int i = 0; i < D - 1; i++) hi[i]  <= p_in[coef_lsb(i + D, N) +: N];
    end else if (fold_en) begin
      acc[k] <= fold_res;
    end
  end

  // Result is the accumulator register, packed coefficient 0 at the LSB.
  for (genvar g = 0; g < D; g++) begin : g_rout
    assign r_out[coef_lsb(g, N) +: N] = acc[g];
  end

endmodule
